// File: rtl/engine_rpm_gen_pkg.sv
// Shared constants, FSM state type and gear-ratio lookup for the engine rpm model.
// Build option REV_LIMITER_CUT_EN is consumed by the top (engine_rpm_gen.sv).
package engine_rpm_gen_pkg;

  localparam int RPM_W      = 14;
  localparam int PROD_W     = 17;
  localparam int RATIO_W    = 3;
  localparam int DIV_CYCLES = 17;

  localparam logic [RPM_W-1:0] IDLE_RPM   = 14'd1000;
  localparam logic [RPM_W-1:0] MAX_RPM    = 14'd8000;
  localparam logic [RPM_W-1:0] ACCEL_STEP = 14'd96;
  localparam logic [RPM_W-1:0] DECEL_STEP = 14'd32;
  localparam logic [RPM_W-1:0] LIMIT_DROP = 14'd400;

  // RUN integrates throttle; MUL/DIV/APPLY re-solve rpm for a gear change.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MUL   = 2'd1,
    ST_DIV   = 2'd2,
    ST_APPLY = 2'd3
  } rpm_state_e;

  // Gear ratios 1, 2, 3, 5 for gears 0..3.
  function automatic logic [RATIO_W-1:0] gear_ratio(input logic [1:0] g);
    logic [RATIO_W-1:0] r;
    case (g)
      2'd0:    r = 3'd1;
      2'd1:    r = 3'd2;
      2'd2:    r = 3'd3;
      default: r = 3'd5;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/engine_rpm_gen_rpm_ratio_div.sv
// rpm_ratio_div: 17-bit by 3-bit restoring divider, one quotient bit per cycle.
// start loads dividend/divisor; 17 iterations follow. done is high during the
// final iteration, so quotient holds the finished result from the next cycle
// until the following start.
module rpm_ratio_div
  import engine_rpm_gen_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [PROD_W-1:0]  dividend,
  input  logic [RATIO_W-1:0] divisor,
  output logic               done,
  output logic [PROD_W-1:0]  quotient
);

  logic [RATIO_W-1:0] rem;
  logic [PROD_W-1:0]  quo;
  logic [RATIO_W-1:0] dvs;
  logic [4:0]         count;

  logic [RATIO_W:0]   trial;
  logic               fits;
  logic [RATIO_W-1:0] rem_next;

  // One restoring step: bring down the next dividend bit, subtract if it fits.
  always_comb begin
    trial    = {rem, quo[PROD_W-1]};
    fits     = (trial >= {1'b0, dvs});
    rem_next = trial[RATIO_W-1:0];
    if (fits) begin
      rem_next = 3'(trial - {1'b0, dvs});
    end
  end

  // Iteration register: load on start, then shift one quotient bit per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      count <= '0;
    end else if (start) begin
      rem   <= '0;
      quo   <= dividend;
      dvs   <= divisor;
      count <= 5'(DIV_CYCLES);
    end else if (count != 5'd0) begin
      rem   <= rem_next;
      quo   <= {quo[PROD_W-2:0], fits};
      count <= count - 5'd1;
    end
  end

  assign done     = (count == 5'd1);
  assign quotient = quo;

endmodule

// File: rtl/engine_rpm_gen.sv
// engine_rpm_gen: rpm integrator and gear-shift FSM for the drag-race engine.
// Build option REV_LIMITER_CUT_EN: when defined, hitting the rev limit bounces
// rpm down by LIMIT_DROP; otherwise rpm saturates at MAX_RPM.
// Shift requests: gear_up/gear_down are single-cycle pulses, only considered
// in RUN (shift_busy low); a request while busy is dropped, a simultaneous
// up+down is dropped, an impossible request yields a one-cycle shift_denied.
module engine_rpm_gen
  import engine_rpm_gen_pkg::*;
(
  input  logic             clk100Hz,
  input  logic             rst,
  input  logic             reset_status,
  input  logic             throttle,
  input  logic             gear_up,
  input  logic             gear_down,
  output logic [RPM_W-1:0] rpm,
  output logic [1:0]       gear,
  output logic             shift_busy,
  output logic             shift_denied,
  output rpm_state_e       fsm_state
);

  rpm_state_e         state, state_next;
  logic [RPM_W-1:0]   rpm_next;
  logic [1:0]         gear_next;
  logic               busy_next;
  logic               denied_next;
  logic [1:0]         target, target_next;

  logic               sync_rst;
  logic               up_only, down_only;
  logic               up_acc, down_acc, req_deny;
  logic [RPM_W:0]     rpm_up;
  logic [RPM_W-1:0]   rpm_accel, rpm_decel;
  logic [PROD_W-1:0]  product;
  logic               div_start, div_done;
  logic [PROD_W-1:0]  div_q;

  assign sync_rst  = rst | reset_status;
  assign up_only   = gear_up & ~gear_down;
  assign down_only = gear_down & ~gear_up;
  assign up_acc    = up_only & (gear != 2'd3);
  assign down_acc  = down_only & (gear != 2'd0);
  assign req_deny  = (up_only & (gear == 2'd3)) | (down_only & (gear == 2'd0));

  // Road-speed product; rpm and gear are frozen while the divider runs.
  assign product   = {3'b000, rpm} * {14'b0, gear_ratio(gear)};
  assign div_start = (state == ST_MUL);

  // Throttle step and limiter, coast step and idle floor.
  always_comb begin
    rpm_up = {1'b0, rpm} + {1'b0, ACCEL_STEP >> gear};
`ifdef REV_LIMITER_CUT_EN
    if (rpm_up >= {1'b0, MAX_RPM}) begin
      rpm_accel = MAX_RPM - LIMIT_DROP;
    end else begin
      rpm_accel = rpm_up[RPM_W-1:0];
    end
`else
    if (rpm_up > {1'b0, MAX_RPM}) begin
      rpm_accel = MAX_RPM;
    end else begin
      rpm_accel = rpm_up[RPM_W-1:0];
    end
`endif
    if (rpm < (IDLE_RPM + DECEL_STEP)) begin
      rpm_decel = IDLE_RPM;
    end else begin
      rpm_decel = rpm - DECEL_STEP;
    end
  end

  rpm_ratio_div u_div (
    .clk      (clk100Hz),
    .rst      (sync_rst),
    .start    (div_start),
    .dividend (product),
    .divisor  (gear_ratio(target)),
    .done     (div_done),
    .quotient (div_q)
  );

  // Next-state and next-output logic for the integrator and shift FSM.
  always_comb begin
    state_next  = state;
    rpm_next    = rpm;
    gear_next   = gear;
    busy_next   = shift_busy;
    denied_next = 1'b0;
    target_next = target;
    case (state)
      ST_RUN: begin
        if (up_acc || down_acc) begin
          target_next = up_acc ? (gear + 2'd1) : (gear - 2'd1);
          busy_next   = 1'b1;
          state_next  = ST_MUL;
        end else begin
          denied_next = req_deny;
          rpm_next    = throttle ? rpm_accel : rpm_decel;
        end
      end
      ST_MUL: begin
        state_next = ST_DIV;
      end
      ST_DIV: begin
        if (div_done) begin
          state_next = ST_APPLY;
        end
      end
      ST_APPLY: begin
        if (div_q > {3'b000, MAX_RPM}) begin
          denied_next = 1'b1;
        end else begin
          gear_next = target;
          rpm_next  = (div_q < {3'b000, IDLE_RPM}) ? IDLE_RPM : div_q[RPM_W-1:0];
        end
        busy_next  = 1'b0;
        state_next = ST_RUN;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // State and registered outputs; either reset source aborts a shift.
  always_ff @(posedge clk100Hz) begin
    if (sync_rst) begin
      state        <= ST_RUN;
      rpm          <= IDLE_RPM;
      gear         <= 2'd0;
      shift_busy   <= 1'b0;
      shift_denied <= 1'b0;
      target       <= 2'd0;
    end else begin
      state        <= state_next;
      rpm          <= rpm_next;
      gear         <= gear_next;
      shift_busy   <= busy_next;
      shift_denied <= denied_next;
      target       <= target_next;
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_engine_rpm_gen.sv
// Bench for engine_rpm_gen: directed scenarios plus random throttle/shift
// traffic, every cycle compared against a transaction-level engine model.
module tb_engine_rpm_gen;
  import engine_rpm_gen_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst, reset_status, throttle, gear_up, gear_down;
  logic [13:0] rpm;
  logic [1:0]  gear;
  logic        shift_busy, shift_denied;
  rpm_state_e  dbg_state;

  always #5 clk = ~clk;

  engine_rpm_gen dut (
    .clk100Hz     (clk),
    .rst          (rst),
    .reset_status (reset_status),
    .throttle     (throttle),
    .gear_up      (gear_up),
    .gear_down    (gear_down),
    .rpm          (rpm),
    .gear         (gear),
    .shift_busy   (shift_busy),
    .shift_denied (shift_denied),
    .fsm_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Engine state plus an outstanding shift: cycles left until it lands,
  // destination gear and the road-speed product taken when it was accepted.
  int m_rpm = 1000, m_gear = 0, m_left = 0, m_to = 0, m_prod = 0;
  int m_denied = 0;
  int m_busy = 0;

  function automatic int ratio(input int g);
    case (g)
      0: return 1;
      1: return 2;
      2: return 3;
      default: return 5;
    endcase
  endfunction

  task automatic model_edge();
    int v, q;
    bit up_only, dn_only;
    if (rst || reset_status) begin
      m_rpm = 1000; m_gear = 0; m_left = 0; m_denied = 0;
    end else begin
      m_denied = 0;
      up_only  = gear_up && !gear_down;
      dn_only  = gear_down && !gear_up;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          q = m_prod / ratio(m_to);
          if (q > 8000) m_denied = 1;
          else begin
            m_gear = m_to;
            m_rpm  = (q < 1000) ? 1000 : q;
          end
        end
      end else if (up_only && m_gear < 3) begin
        m_left = 19; m_to = m_gear + 1; m_prod = m_rpm * ratio(m_gear);
      end else if (dn_only && m_gear > 0) begin
        m_left = 19; m_to = m_gear - 1; m_prod = m_rpm * ratio(m_gear);
      end else begin
        if (up_only || dn_only) m_denied = 1;
        if (throttle) begin
          v = m_rpm + (96 >> m_gear);
`ifdef REV_LIMITER_CUT_EN
          if (v >= 8000) v = 7600;
`else
          if (v > 8000) v = 8000;
`endif
        end else begin
          v = m_rpm - 32;
          if (v < 1000) v = 1000;
        end
        m_rpm = v;
      end
    end
    m_busy = (m_left > 0) ? 1 : 0;
  endtask

  // ---------------- driver ----------------
  // One clock: model follows the edge, DUT outputs compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_val("rpm",    int'(rpm),          m_rpm);
    check_val("gear",   int'(gear),         m_gear);
    check_val("busy",   int'(shift_busy),   m_busy);
    check_val("denied", int'(shift_denied), m_denied);
  endtask

  // ---------------- stimulus ----------------
  int prev, busy_cnt, exp_rpm, saw_bounce;

  initial begin
    rst = 1'b1; reset_status = 1'b0; throttle = 1'b0;
    gear_up = 1'b0; gear_down = 1'b0;
    step(); step();
    check_val("reset_rpm",  int'(rpm), 1000);
    check_val("reset_gear", int'(gear), 0);
    rst = 1'b0;

    // Ten throttle ticks then ten coast ticks in gear 0.
    throttle = 1'b1;
    repeat (10) step();
    check_val("accel10", int'(rpm), 1960);
    throttle = 1'b0;
    repeat (10) step();
    check_val("decel10", int'(rpm), 1640);

    // Downshift from gear 0 is denied with a single pulse.
    gear_down = 1'b1;
    step();
    gear_down = 1'b0;
    check_val("deny_g0", int'(shift_denied), 1);
    step();
    check_val("deny_clear", int'(shift_denied), 0);

    // Hold throttle into the rev limit.
    throttle = 1'b1;
    saw_bounce = 0;
    for (int i = 0; i < 90; i++) begin
      prev = int'(rpm);
      step();
      if (prev >= 7904 && int'(rpm) == 7600) saw_bounce = 1;
    end
`ifdef REV_LIMITER_CUT_EN
    check_val("limit_bounce", saw_bounce, 1);
`else
    check_val("limit_sat", int'(rpm), 8000);
    check_val("limit_no_bounce", saw_bounce, 0);
`endif

    // Upshift 0->1: busy for 19 cycles, rpm halves; a request while busy is dropped.
    exp_rpm = m_rpm / 2;
    if (exp_rpm < 1000) exp_rpm = 1000;
    gear_up = 1'b1;
    step();
    gear_up = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 30 && shift_busy; i++) begin
      busy_cnt++;
      gear_up = (i == 5);
      step();
    end
    gear_up = 1'b0;
    check_val("up_busy_cycles", busy_cnt, 19);
    check_val("up_gear", int'(gear), 1);
    check_val("up_rpm", int'(rpm), exp_rpm);

    // Downshift 1->0 with rpm above 4000 lands above the limit: denied.
    for (int i = 0; i < 100 && m_rpm <= 4050; i++) step();
    gear_down = 1'b1;
    step();
    gear_down = 1'b0;
    exp_rpm = m_rpm;
    repeat (19) step();
    check_val("down_deny_pulse", int'(shift_denied), 1);
    check_val("down_deny_gear", int'(gear), 1);
    check_val("down_deny_rpm", int'(rpm), exp_rpm);

    // Race restart in the middle of a divide.
    gear_up = 1'b1;
    step();
    gear_up = 1'b0;
    repeat (8) step();
    check_val("mid_div_busy", int'(shift_busy), 1);
    reset_status = 1'b1;
    step();
    reset_status = 1'b0;
    check_val("rs_rpm", int'(rpm), 1000);
    check_val("rs_gear", int'(gear), 0);
    check_val("rs_busy", int'(shift_busy), 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      throttle     = ($urandom_range(0, 99) < 70);
      gear_up      = ($urandom_range(0, 19) == 0);
      gear_down    = ($urandom_range(0, 19) == 1);
      reset_status = ($urandom_range(0, 599) == 0);
      rst          = ($urandom_range(0, 1499) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
